adder_share_ctrl_64: RTL and testbench

- Controller that time-shares one combinational 64-bit adder instance (external, combinational, A/B/carry-in -> SUM/carry-out) between NREQ requesters.
- Does round-robin arbitration, registers the operands to drive the shared adder, captures the result and returns it with the requester ID over a valid/ready response port.
- Supports ADD and SUB with carry/borrow chaining, so software can build multi-word arithmetic. Sits between the integer execute units and the shared adder datapath.

---
 rtl/adder_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/adder_share_ctrl_64.sv | 111 +++++++++++
 tb/tb_adder_share_ctrl_64.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the time-shared adder controller.
// Imported by the controller top and its arbiter.
package adder_ctrl_pkg;

  localparam int WIDTH_DEF = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic [2:0] id;
    logic       sub;
    logic       a_msb;
  } iss_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating
// pointer; the pointer moves past the winner whenever a grant is taken.
module rr_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win,
  output logic            hit
);

  logic [IDW-1:0] ptr;
  logic           found;
  int             idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    grant = '0;
    if (found && adv) begin
      grant[win] = 1'b1;
    end
  end

  assign hit = found && adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/adder_share_ctrl_64.sv
// Time-shares one external combinational adder among NREQ requesters:
// arbitrate -> issue register (drives adder) -> out register (response).
module adder_share_ctrl_64
  import adder_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ_VALID,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [NREQ*WIDTH-1:0] REQ_A,
  input  logic [NREQ*WIDTH-1:0] REQ_B,
  input  logic [NREQ-1:0]   REQ_SUB,
  input  logic [NREQ-1:0]   REQ_CIN,
  output logic [WIDTH-1:0]  ADD_A,
  output logic [WIDTH-1:0]  ADD_B,
  output logic              ADD_CIN,
  input  logic [WIDTH-1:0]  ADD_SUM,
  input  logic              ADD_COUT,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IDW-1:0]    RSP_ID,
  output logic [WIDTH-1:0]  RSP_SUM,
  output logic              RSP_COUT,
  output logic              RSP_OVF
);

  logic            iss_v;
  logic            out_v;
  logic            iss_adv;
  logic            out_adv;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic            acc;
  iss_rec_t        rec;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             sub_sel;
  logic             cin_sel;

  assign out_adv = !out_v || RSP_READY;
  assign iss_adv = !iss_v || out_adv;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk   (CLK),
    .rst_n (RST_N),
    .req   (REQ_VALID),
    .adv   (iss_adv),
    .grant (grant),
    .win   (win),
    .hit   (acc)
  );

  assign REQ_READY = grant;
  assign RSP_VALID = out_v;

  always_comb begin
    a_sel   = REQ_A[int'(win)*WIDTH +: WIDTH];
    b_sel   = REQ_B[int'(win)*WIDTH +: WIDTH];
    sub_sel = REQ_SUB[win];
    cin_sel = REQ_CIN[win];
  end

  // adder inputs only change on a real accept
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iss_v   <= 1'b0;
      ADD_A   <= '0;
      ADD_B   <= '0;
      ADD_CIN <= 1'b0;
      rec     <= '0;
    end else if (iss_adv) begin
      iss_v <= acc;
      if (acc) begin
        ADD_A   <= a_sel;
        ADD_B   <= (sub_sel == OP_SUB) ? ~b_sel : b_sel;
        ADD_CIN <= (sub_sel == OP_SUB) ? ~cin_sel : cin_sel;
        rec.id    <= 3'(win);
        rec.sub   <= sub_sel;
        rec.a_msb <= a_sel[WIDTH-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_v    <= 1'b0;
      RSP_ID   <= '0;
      RSP_SUM  <= '0;
      RSP_COUT <= 1'b0;
      RSP_OVF  <= 1'b0;
    end else if (out_adv) begin
      out_v <= iss_v;
      if (iss_v) begin
        RSP_SUM  <= ADD_SUM;
        RSP_COUT <= (rec.sub == OP_SUB) ? ~ADD_COUT : ADD_COUT;
        RSP_OVF  <= (rec.a_msb == ADD_B[WIDTH-1])
                 && (ADD_SUM[WIDTH-1] != rec.a_msb);
        RSP_ID   <= IDW'(rec.id);
      end
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl_64.sv
// Scoreboard bench for adder_share_ctrl_64 with an ideal adder attached.
// Expected results come from wide-integer arithmetic on the issued operands.
module tb_adder_share_ctrl_64;

  localparam int N = 4;
  localparam int W = 64;

  logic           CLK;
  logic           RST_N;
  logic [N-1:0]   REQ_VALID;
  logic [N-1:0]   REQ_READY;
  logic [N*W-1:0] REQ_A;
  logic [N*W-1:0] REQ_B;
  logic [N-1:0]   REQ_SUB;
  logic [N-1:0]   REQ_CIN;
  logic [W-1:0]   ADD_A;
  logic [W-1:0]   ADD_B;
  logic           ADD_CIN;
  logic [W-1:0]   ADD_SUM;
  logic           ADD_COUT;
  logic           RSP_VALID;
  logic           RSP_READY;
  logic [1:0]     RSP_ID;
  logic [W-1:0]   RSP_SUM;
  logic           RSP_COUT;
  logic           RSP_OVF;

  adder_share_ctrl_64 dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_SUB   (REQ_SUB),
    .REQ_CIN   (REQ_CIN),
    .ADD_A     (ADD_A),
    .ADD_B     (ADD_B),
    .ADD_CIN   (ADD_CIN),
    .ADD_SUM   (ADD_SUM),
    .ADD_COUT  (ADD_COUT),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_ID    (RSP_ID),
    .RSP_SUM   (RSP_SUM),
    .RSP_COUT  (RSP_COUT),
    .RSP_OVF   (RSP_OVF)
  );

  // the shared adder that the parent would normally provide
  assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B} + {64'd0, ADD_CIN};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int         id;
    logic [63:0] sum;
    logic       cout;
    logic       ovf;
    logic       lat;
    int         cyc;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int ptr_m = 0;
  int to_req = 0;
  int to_seen = 0;
  int bp_req = 0;
  int bp_seen = 0;
  int bp_base = 0;
  int end_req = 0;
  int end_seen = 0;
  logic free_run = 1'b0;

  function automatic exp_t ref_op(int id, logic [63:0] a, logic [63:0] b,
                                  logic sub, logic cin, logic lat, int c);
    exp_t e;
    logic [64:0] u;
    logic [66:0] sa, sb, sr;
    sa = {{3{a[63]}}, a};
    sb = {{3{b[63]}}, b};
    if (sub) begin
      u  = {1'b0, a} - {1'b0, b} - {64'd0, cin};
      sr = sa - sb - {66'd0, cin};
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      sr = sa + sb + {66'd0, cin};
    end
    e.id   = id;
    e.sum  = u[63:0];
    e.cout = u[64];
    e.ovf  = (sr != {{3{u[63]}}, u[63:0]});
    e.lat  = lat;
    e.cyc  = c;
    return e;
  endfunction

  // monitor: all comparisons live here
  initial begin : mon
    logic        hold;
    logic [1:0]  h_id;
    logic [63:0] h_sum;
    logic        h_cout, h_ovf;
    int          w, idx;
    exp_t        e;
    hold = 1'b0;
    h_id = '0; h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (to_req != to_seen) begin
        to_seen = to_req;
        total++; bad++;
        $display("FAIL timeout: handshake wait expired got=none need=accept");
      end
      if (!RST_N) begin
        total++;
        if (REQ_READY != 0 || RSP_VALID || RSP_ID != 0 || RSP_SUM != 0 ||
            RSP_COUT || RSP_OVF || ADD_A != 0 || ADD_B != 0 || ADD_CIN) begin
          bad++;
          $display("FAIL reset_state: rdy=%h vld=%b id=%0d sum=%h co=%b ov=%b adda=%h addb=%h ci=%b need all zero",
                   REQ_READY, RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF,
                   ADD_A, ADD_B, ADD_CIN);
        end
        q.delete();
        ptr_m = 0;
        hold = 1'b0;
      end else begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          idx = (ptr_m + k) % N;
          if (w < 0 && REQ_VALID[idx]) w = idx;
        end
        if (REQ_READY != 0) begin
          total++;
          if (w < 0 || REQ_READY != (4'b0001 << w)) begin
            bad++;
            $display("FAIL rr_grant: got=%b need_winner=%0d valid=%b",
                     REQ_READY, w, REQ_VALID);
          end
        end
        if (w >= 0 && REQ_READY[w] && REQ_VALID[w]) begin
          q.push_back(ref_op(w, REQ_A[w*W +: W], REQ_B[w*W +: W],
                             REQ_SUB[w], REQ_CIN[w], free_run, cyc));
          acc_cnt++;
          ptr_m = (w + 1) % N;
        end
        if (hold) begin
          total++;
          if (!RSP_VALID || RSP_ID != h_id || RSP_SUM != h_sum ||
              RSP_COUT != h_cout || RSP_OVF != h_ovf) begin
            bad++;
            $display("FAIL rsp_hold: got v=%b id=%0d sum=%h co=%b ov=%b need v=1 id=%0d sum=%h co=%b ov=%b",
                     RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF,
                     h_id, h_sum, h_cout, h_ovf);
          end
        end
        if (RSP_VALID && q.size() == 0) begin
          total++; bad++;
          $display("FAIL stale_rsp: got id=%0d sum=%h need no response", RSP_ID, RSP_SUM);
        end else if (RSP_VALID && RSP_READY) begin
          e = q.pop_front();
          total++;
          if (int'(RSP_ID) != e.id || RSP_SUM != e.sum ||
              RSP_COUT != e.cout || RSP_OVF != e.ovf) begin
            bad++;
            $display("FAIL rsp_data: got id=%0d sum=%h co=%b ov=%b need id=%0d sum=%h co=%b ov=%b",
                     RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF, e.id, e.sum, e.cout, e.ovf);
          end
          if (e.lat && free_run) begin
            total++;
            if (cyc - e.cyc != 2) begin
              bad++;
              $display("FAIL latency: got=%0d need=2", cyc - e.cyc);
            end
          end
        end
        hold = RSP_VALID && !RSP_READY;
        h_id = RSP_ID; h_sum = RSP_SUM; h_cout = RSP_COUT; h_ovf = RSP_OVF;
      end
      if (bp_req != bp_seen) begin
        bp_seen = bp_req;
        total++;
        if (acc_cnt - bp_base != 2 || REQ_READY != 0) begin
          bad++;
          $display("FAIL backpressure: got accepts=%0d rdy=%b need accepts=2 rdy=0",
                   acc_cnt - bp_base, REQ_READY);
        end
      end
      if (end_req != end_seen) begin
        end_seen = end_req;
        total++;
        if (q.size() != 0) begin
          bad++;
          $display("FAIL drain: got pending=%0d need=0", q.size());
        end
      end
    end
  end

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0: rnd64 = 64'hFFFF_FFFF_FFFF_FFFF;
      1: rnd64 = 64'h8000_0000_0000_0000;
      2: rnd64 = 64'h7FFF_FFFF_FFFF_FFFF;
      3: rnd64 = 64'(int'($urandom_range(0, 3)));
      default: rnd64 = {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic cin);
    REQ_A[i*W +: W] = a;
    REQ_B[i*W +: W] = b;
    REQ_SUB[i] = sub;
    REQ_CIN[i] = cin;
  endtask

  task automatic send(input int i, input logic [63:0] a, input logic [63:0] b,
                      input logic sub, input logic cin);
    bit got;
    got = 1'b0;
    set_op(i, a, b, sub, cin);
    REQ_VALID[i] = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge CLK);
      if (REQ_READY[i]) got = 1'b1;
    end
    if (!got) to_req++;
    @(posedge CLK); #1;
    REQ_VALID[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    REQ_VALID = '0;
    REQ_A = '0;
    REQ_B = '0;
    REQ_SUB = '0;
    REQ_CIN = '0;
    RSP_READY = 1'b1;
    idle(3);
    RST_N = 1'b1;
    free_run = 1'b1;
    idle(1);

    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    idle(3);
    send(2, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    idle(3);

    REQ_VALID = 4'hF;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++)
        set_op(i, rnd64(), rnd64(), 1'($urandom), 1'($urandom));
      idle(1);
    end
    REQ_VALID = '0;
    idle(4);

    free_run = 1'b0;
    RSP_READY = 1'b0;
    set_op(1, 64'd100, 64'd7, 1'b0, 1'b1);
    set_op(3, 64'd5, 64'd9, 1'b1, 1'b0);
    REQ_VALID = 4'b1010;
    bp_base = acc_cnt;
    idle(5);
    bp_req++;
    idle(1);
    REQ_VALID = '0;
    RSP_READY = 1'b1;
    idle(4);

    free_run = 1'b1;
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    send(1, 64'd0, 64'd0, 1'b0, 1'b1);
    idle(4);

    free_run = 1'b0;
    for (int c = 0; c < 300; c++) begin
      REQ_VALID = 4'($urandom);
      for (int i = 0; i < N; i++)
        set_op(i, rnd64(), rnd64(), 1'($urandom), 1'($urandom));
      RSP_READY = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    REQ_VALID = '0;
    RSP_READY = 1'b1;
    idle(4);

    RSP_READY = 1'b0;
    REQ_VALID = 4'hF;
    idle(4);
    #2;
    RST_N = 1'b0;
    REQ_VALID = '0;
    idle(2);
    RST_N = 1'b1;
    RSP_READY = 1'b1;
    free_run = 1'b1;
    set_op(0, 64'd11, 64'd22, 1'b0, 1'b0);
    set_op(2, 64'd33, 64'd44, 1'b1, 1'b1);
    REQ_VALID = 4'b0101;
    idle(6);
    REQ_VALID = '0;
    idle(5);

    end_req++;
    @(negedge CLK);
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
